tx_frame_arbiter: RTL and testbench

// - Shares the single MAC transmit path between two show-ahead frame buffers (port A, port B).
// - Grants one whole frame at a time, round-robin; streams it as valid/ready/last bytes to the MAC.
// - Pads runt frames to MIN_LEN, flushes illegal lengths, and inserts an inter-frame gap.
// - Sits between the per-port RX frame buffers and the TX MAC interface.

---
 rtl/tx_frame_arbiter.sv | 158 +++++++++++++++
 tb/tb_tx_frame_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter that moves whole frames from two show-ahead buffers onto the
// MAC transmit stream, padding runts, flushing illegal lengths and enforcing the IFG.
module tx_frame_arbiter #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int IFG     = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_frm_rdy,
  input  logic [15:0] a_len,
  input  logic [7:0]  a_data,
  output logic        a_pop,
  input  logic        b_frm_rdy,
  input  logic [15:0] b_len,
  input  logic [7:0]  b_data,
  output logic        b_pop,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic [1:0]  grant,
  output logic        frm_drop
);

  localparam logic [15:0] MIN_L    = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L    = 16'(MAX_LEN);
  localparam logic [15:0] IFG_LAST = 16'(IFG - 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, SEND, PAD, DRAIN, FLUSH, GAP
  } state_t;

  state_t      state, state_d;
  logic [15:0] len_q, len_d, cnt_q, cnt_d, ifg_q, ifg_d;
  logic        rr_last_q, rr_last_d;
  logic [1:0]  grant_d;
  logic [7:0]  tx_data_d;
  logic        tx_valid_d, tx_last_d, drop_d;
  logic        pop, pick_b, adv;
  logic [15:0] eff_len, cnt_inc;
  logic [7:0]  src_data;

  assign adv      = !tx_valid || tx_ready;
  assign src_data = grant[1] ? b_data : a_data;
  assign eff_len  = (len_q < MIN_L) ? MIN_L : len_q;
  assign cnt_inc  = cnt_q + 16'd1;
  assign a_pop    = pop && grant[0];
  assign b_pop    = pop && grant[1];

  // rr_last resets to B (1) so that port A wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      len_q     <= 16'd0;
      cnt_q     <= 16'd0;
      ifg_q     <= 16'd0;
      rr_last_q <= 1'b1;
      grant     <= 2'b00;
      tx_data   <= 8'd0;
      tx_valid  <= 1'b0;
      tx_last   <= 1'b0;
      frm_drop  <= 1'b0;
    end else begin
      state     <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      ifg_q     <= ifg_d;
      rr_last_q <= rr_last_d;
      grant     <= grant_d;
      tx_data   <= tx_data_d;
      tx_valid  <= tx_valid_d;
      tx_last   <= tx_last_d;
      frm_drop  <= drop_d;
    end
  end

  always_comb begin
    state_d    = state;
    len_d      = len_q;
    cnt_d      = cnt_q;
    ifg_d      = ifg_q;
    rr_last_d  = rr_last_q;
    grant_d    = grant;
    tx_data_d  = tx_data;
    tx_valid_d = tx_valid;
    tx_last_d  = tx_last;
    drop_d     = 1'b0;
    pop        = 1'b0;
    pick_b     = 1'b0;

    unique case (state)
      IDLE: begin
        if (a_frm_rdy || b_frm_rdy) begin
          pick_b  = b_frm_rdy && (!a_frm_rdy || !rr_last_q);
          grant_d = pick_b ? 2'b10 : 2'b01;
          len_d   = pick_b ? b_len : a_len;
          cnt_d   = 16'd0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = (len_q == 16'd0 || len_q > MAX_L) ? FLUSH : SEND;
      end
      SEND: begin
        if (adv && cnt_q < len_q) begin
          tx_data_d  = src_data;
          tx_valid_d = 1'b1;
          tx_last_d  = (cnt_inc == eff_len);
          pop        = 1'b1;
          cnt_d      = cnt_inc;
          if (cnt_inc == len_q)
            state_d = (len_q < MIN_L) ? PAD : DRAIN;
        end
      end
      PAD: begin
        if (adv) begin
          tx_data_d  = 8'd0;
          tx_valid_d = 1'b1;
          tx_last_d  = (cnt_inc == eff_len);
          cnt_d      = cnt_inc;
          if (cnt_inc == MIN_L)
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          rr_last_d  = grant[1];
          grant_d    = 2'b00;
          ifg_d      = 16'd0;
          state_d    = GAP;
        end
      end
      FLUSH: begin
        // A zero-length frame still passes through here so frm_drop fires once.
        if (cnt_q < len_q) begin
          pop   = 1'b1;
          cnt_d = cnt_inc;
        end
        if (len_q == 16'd0 || cnt_inc == len_q) begin
          drop_d    = 1'b1;
          rr_last_d = grant[1];
          grant_d   = 2'b00;
          ifg_d     = 16'd0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (ifg_q == IFG_LAST) state_d = IDLE;
        else                   ifg_d   = ifg_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed self-checking bench for tx_frame_arbiter with show-ahead buffer models
// on both ports and a negedge monitor that records handshakes, pops and grants.
module tb_tx_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] a_len = 16'd0, b_len = 16'd0;
  logic        tx_ready = 1'b1;
  logic        a_frm_rdy, b_frm_rdy, a_pop, b_pop;
  logic [7:0]  a_data, b_data, tx_data;
  logic        tx_valid, tx_last, frm_drop;
  logic [1:0]  grant;

  int a_total = 0, b_total = 0, a_done = 0, b_done = 0, a_idx = 0, b_idx = 0;
  logic [1:0] g_prev = 2'b00;

  int errors = 0, checks = 0;

  int cyc = 0, a_pops = 0, b_pops = 0, pop_err = 0, stall_err = 0, stalls = 0;
  int drops = 0, valid_b = 0;
  logic [7:0] hs_data[$];
  logic       hs_last[$];
  int         hs_cyc[$];
  logic [1:0] gr_val[$];
  int         gr_cyc[$];
  int         vr_cyc[$];
  logic [1:0] mon_prev_grant = 2'b00;
  logic       mon_prev_valid = 1'b0;
  logic       stall_pending = 1'b0;
  logic [7:0] stall_data = 8'd0;
  logic       stall_last = 1'b0;

  function automatic logic [7:0] pat(input int port, input int seed, input int idx);
    int v;
    v = seed * 37 + idx * 13 + port * 101 + 5;
    return v[7:0];
  endfunction

  assign a_frm_rdy = (a_total > a_done);
  assign b_frm_rdy = (b_total > b_done);
  assign a_data    = pat(0, a_done, a_idx);
  assign b_data    = pat(1, b_done, b_idx);

  tx_frame_arbiter dut (
    .clk(clk), .rst(rst),
    .a_frm_rdy(a_frm_rdy), .a_len(a_len), .a_data(a_data), .a_pop(a_pop),
    .b_frm_rdy(b_frm_rdy), .b_len(b_len), .b_data(b_data), .b_pop(b_pop),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .grant(grant), .frm_drop(frm_drop)
  );

  always #5 clk = ~clk;

  // Buffer model: a frame is retired when its grant drops; reset discards pending frames.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_done <= a_total;
      b_done <= b_total;
      a_idx  <= 0;
      b_idx  <= 0;
      g_prev <= 2'b00;
    end else begin
      g_prev <= grant;
      if (a_pop) a_idx <= a_idx + 1;
      if (b_pop) b_idx <= b_idx + 1;
      if (g_prev[0] && !grant[0]) begin a_done <= a_done + 1; a_idx <= 0; end
      if (g_prev[1] && !grant[1]) begin b_done <= b_done + 1; b_idx <= 0; end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (tx_valid && tx_ready) begin
        hs_data.push_back(tx_data);
        hs_last.push_back(tx_last);
        hs_cyc.push_back(cyc);
      end
      if (a_pop) a_pops++;
      if (b_pop) b_pops++;
      if (a_pop && b_pop) pop_err++;
      if ((a_pop || b_pop) && tx_valid && !tx_ready) pop_err++;
      if (tx_valid && grant == 2'b10) valid_b++;
      if (tx_valid && !tx_ready) stalls++;
      if (grant != 2'b00 && mon_prev_grant == 2'b00) begin
        gr_val.push_back(grant);
        gr_cyc.push_back(cyc);
      end
      if (tx_valid && !mon_prev_valid) vr_cyc.push_back(cyc);
      if (frm_drop) drops++;
      if (stall_pending && (!tx_valid || tx_data != stall_data || tx_last != stall_last))
        stall_err++;
    end
    stall_pending  = rst && tx_valid && !tx_ready;
    stall_data     = tx_data;
    stall_last     = tx_last;
    mon_prev_grant = grant;
    mon_prev_valid = tx_valid;
  end

  task automatic wait_hs(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (hs_data.size() >= target && grant == 2'b00) begin ok = 1'b1; break; end
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_last: got %b want 0", tx_last); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (grant !== 2'b00) begin errors++; $display("[TB] FAIL reset_grant: got %b want 00", grant); end
    checks++; if (frm_drop !== 1'b0) begin errors++; $display("[TB] FAIL reset_frm_drop: got %b want 0", frm_drop); end
    checks++; if ({a_pop, b_pop} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pops: got %b want 00", {a_pop, b_pop}); end
    rst = 1'b1;
    settle(5);
    checks++; if (grant !== 2'b00) begin errors++; $display("[TB] FAIL idle_grant: got %b want 00", grant); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_tx_valid: got %b want 0", tx_valid); end
  endtask

  task automatic test_round_robin();
    int h0, g0, a0, b0, derr, f, p, seed;
    bit ok;
    logic [1:0] exp_g;
    logic [7:0] exp_d;
    h0 = hs_data.size(); g0 = gr_val.size(); a0 = a_done; b0 = b_done;
    a_len = 16'd64; b_len = 16'd64;
    a_total += 4; b_total += 4;
    wait_hs(h0 + 512, 2000, ok);
    settle(16);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rr_timeout: got %0d bytes want 512", hs_data.size() - h0); end
    checks++; if (hs_data.size() - h0 != 512) begin errors++; $display("[TB] FAIL rr_bytes: got %0d want 512", hs_data.size() - h0); end
    for (int k = 0; k < 8; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (gr_val.size() <= g0 + k || gr_val[g0 + k] !== exp_g) begin
        errors++;
        $display("[TB] FAIL rr_grant%0d: got %b want %b", k, (gr_val.size() > g0 + k) ? gr_val[g0 + k] : 2'bxx, exp_g);
      end
    end
    derr = 0;
    for (int h = 0; h < 512 && h0 + h < hs_data.size(); h++) begin
      f = h / 64; p = f % 2;
      seed = (p == 0 ? a0 : b0) + f / 2;
      exp_d = pat(p, seed, h % 64);
      if (hs_data[h0 + h] !== exp_d) derr++;
    end
    checks++; if (derr != 0) begin errors++; $display("[TB] FAIL rr_data: got %0d bad bytes want 0", derr); end
  endtask

  task automatic test_single_a();
    int h0, g0, v0, ap0, bp0, seed, derr, lerr;
    bit ok;
    h0 = hs_data.size(); g0 = gr_val.size(); v0 = vr_cyc.size();
    ap0 = a_pops; bp0 = b_pops; seed = a_done;
    a_len = 16'd100; a_total++;
    wait_hs(h0 + 100, 400, ok);
    settle(16);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL single_timeout: got %0d bytes want 100", hs_data.size() - h0); end
    checks++; if (hs_data.size() - h0 != 100) begin errors++; $display("[TB] FAIL single_bytes: got %0d want 100", hs_data.size() - h0); end
    derr = 0; lerr = 0;
    for (int i = 0; i < 100 && h0 + i < hs_data.size(); i++) begin
      if (hs_data[h0 + i] !== pat(0, seed, i)) derr++;
      if (hs_last[h0 + i] !== (i == 99)) lerr++;
    end
    checks++; if (derr != 0) begin errors++; $display("[TB] FAIL single_data: got %0d bad bytes want 0", derr); end
    checks++; if (lerr != 0) begin errors++; $display("[TB] FAIL single_last: got %0d misplaced want 0", lerr); end
    checks++; if (a_pops - ap0 != 100) begin errors++; $display("[TB] FAIL single_a_pops: got %0d want 100", a_pops - ap0); end
    checks++; if (b_pops - bp0 != 0) begin errors++; $display("[TB] FAIL single_b_pops: got %0d want 0", b_pops - bp0); end
    checks++;
    if (gr_val.size() <= g0 || vr_cyc.size() <= v0 || vr_cyc[v0] - gr_cyc[g0] != 2) begin
      errors++;
      $display("[TB] FAIL single_latency: got %0d want 2", (gr_val.size() > g0 && vr_cyc.size() > v0) ? vr_cyc[v0] - gr_cyc[g0] : -1);
    end
  endtask

  task automatic test_runt();
    int h0, ap0, seed, derr, lerr;
    bit ok;
    logic [7:0] exp_d;
    h0 = hs_data.size(); ap0 = a_pops; seed = a_done;
    a_len = 16'd20; a_total++;
    wait_hs(h0 + 64, 300, ok);
    settle(16);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL runt_timeout: got %0d bytes want 64", hs_data.size() - h0); end
    checks++; if (hs_data.size() - h0 != 64) begin errors++; $display("[TB] FAIL runt_bytes: got %0d want 64", hs_data.size() - h0); end
    derr = 0; lerr = 0;
    for (int i = 0; i < 64 && h0 + i < hs_data.size(); i++) begin
      exp_d = (i < 20) ? pat(0, seed, i) : 8'h00;
      if (hs_data[h0 + i] !== exp_d) derr++;
      if (hs_last[h0 + i] !== (i == 63)) lerr++;
    end
    checks++; if (derr != 0) begin errors++; $display("[TB] FAIL runt_data: got %0d bad bytes want 0", derr); end
    checks++; if (lerr != 0) begin errors++; $display("[TB] FAIL runt_last: got %0d misplaced want 0", lerr); end
    checks++; if (a_pops - ap0 != 20) begin errors++; $display("[TB] FAIL runt_a_pops: got %0d want 20", a_pops - ap0); end
  endtask

  task automatic test_back_to_back();
    int h0, g0, gap;
    bit ok;
    h0 = hs_data.size(); g0 = gr_val.size();
    a_len = 16'd64; a_total += 2;
    wait_hs(h0 + 128, 500, ok);
    settle(16);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_timeout: got %0d bytes want 128", hs_data.size() - h0); end
    checks++; if (gr_val.size() - g0 != 2) begin errors++; $display("[TB] FAIL b2b_grants: got %0d want 2", gr_val.size() - g0); end
    gap = (gr_val.size() >= g0 + 2 && hs_data.size() >= h0 + 64) ? gr_cyc[g0 + 1] - hs_cyc[h0 + 63] : -1;
    checks++; if (gap != 14) begin errors++; $display("[TB] FAIL b2b_ifg: got %0d cycles want 14", gap); end
  endtask

  task automatic test_stall();
    int h0, ap0, se0, pe0, st0, seed, derr, lerr;
    bit ok;
    h0 = hs_data.size(); ap0 = a_pops; se0 = stall_err; pe0 = pop_err; st0 = stalls; seed = a_done;
    ok = 1'b0;
    a_len = 16'd70; a_total++;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      tx_ready = ($urandom_range(0, 1) == 1);
      if (hs_data.size() >= h0 + 70 && grant == 2'b00) begin ok = 1'b1; break; end
    end
    tx_ready = 1'b1;
    settle(16);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL stall_timeout: got %0d bytes want 70", hs_data.size() - h0); end
    checks++; if (hs_data.size() - h0 != 70) begin errors++; $display("[TB] FAIL stall_bytes: got %0d want 70", hs_data.size() - h0); end
    derr = 0; lerr = 0;
    for (int i = 0; i < 70 && h0 + i < hs_data.size(); i++) begin
      if (hs_data[h0 + i] !== pat(0, seed, i)) derr++;
      if (hs_last[h0 + i] !== (i == 69)) lerr++;
    end
    checks++; if (derr != 0) begin errors++; $display("[TB] FAIL stall_data: got %0d bad bytes want 0", derr); end
    checks++; if (lerr != 0) begin errors++; $display("[TB] FAIL stall_last: got %0d misplaced want 0", lerr); end
    checks++; if (stall_err - se0 != 0) begin errors++; $display("[TB] FAIL stall_hold: got %0d unstable cycles want 0", stall_err - se0); end
    checks++; if (pop_err - pe0 != 0) begin errors++; $display("[TB] FAIL stall_pop: got %0d bad pops want 0", pop_err - pe0); end
    checks++; if (a_pops - ap0 != 70) begin errors++; $display("[TB] FAIL stall_a_pops: got %0d want 70", a_pops - ap0); end
    checks++; if (stalls - st0 < 1) begin errors++; $display("[TB] FAIL stall_seen: got %0d stall cycles want >0", stalls - st0); end
  endtask

  task automatic test_flush();
    int h0, g0, bp0, ap0, dr0, vb0, seed, derr;
    bit ok;
    logic [7:0] exp_d;
    g0 = gr_val.size(); bp0 = b_pops; dr0 = drops; vb0 = valid_b;
    b_len = 16'd0; b_total++;
    settle(30);
    checks++; if (b_pops - bp0 != 0) begin errors++; $display("[TB] FAIL flush0_pops: got %0d want 0", b_pops - bp0); end
    checks++; if (drops - dr0 != 1) begin errors++; $display("[TB] FAIL flush0_drop: got %0d want 1", drops - dr0); end
    checks++; if (gr_val.size() <= g0 || gr_val[g0] !== 2'b10) begin errors++; $display("[TB] FAIL flush0_grant: got %0d grants want one B", gr_val.size() - g0); end

    h0 = hs_data.size(); g0 = gr_val.size(); bp0 = b_pops; ap0 = a_pops; dr0 = drops; vb0 = valid_b;
    ok = 1'b0;
    b_len = 16'd2000; b_total++;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (grant == 2'b10) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("[TB] FAIL flush_grant_b: got %b want 10", grant); end
    seed = a_done;
    a_len = 16'd30; a_total++;
    wait_hs(h0 + 64, 2600, ok);
    settle(16);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL flush_timeout: got %0d bytes want 64", hs_data.size() - h0); end
    checks++; if (b_pops - bp0 != 2000) begin errors++; $display("[TB] FAIL flush_b_pops: got %0d want 2000", b_pops - bp0); end
    checks++; if (drops - dr0 != 1) begin errors++; $display("[TB] FAIL flush_drop: got %0d want 1", drops - dr0); end
    checks++; if (valid_b - vb0 != 0) begin errors++; $display("[TB] FAIL flush_valid: got %0d valid cycles want 0", valid_b - vb0); end
    checks++; if (gr_val.size() < g0 + 2 || gr_val[g0 + 1] !== 2'b01) begin errors++; $display("[TB] FAIL flush_then_a: got %0d grants want B then A", gr_val.size() - g0); end
    checks++; if (a_pops - ap0 != 30) begin errors++; $display("[TB] FAIL flush_a_pops: got %0d want 30", a_pops - ap0); end
    derr = 0;
    for (int i = 0; i < 64 && h0 + i < hs_data.size(); i++) begin
      exp_d = (i < 30) ? pat(0, seed, i) : 8'h00;
      if (hs_data[h0 + i] !== exp_d) derr++;
    end
    checks++; if (derr != 0 || hs_data.size() - h0 != 64) begin errors++; $display("[TB] FAIL flush_a_data: got %0d bad of %0d bytes want 0 of 64", derr, hs_data.size() - h0); end
  endtask

  task automatic test_reset_abort();
    int h0, ap0, g0;
    bit ok;
    h0 = hs_data.size();
    ok = 1'b0;
    a_len = 16'd100; a_total++;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (hs_data.size() >= h0 + 30) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("[TB] FAIL abort_timeout: got %0d bytes want 30", hs_data.size() - h0); end
    rst = 1'b0;
    #1;
    checks++; if ({tx_valid, tx_last, frm_drop, a_pop, b_pop} !== 5'b0) begin errors++; $display("[TB] FAIL abort_ctrl: got %b want 00000", {tx_valid, tx_last, frm_drop, a_pop, b_pop}); end
    checks++; if (grant !== 2'b00) begin errors++; $display("[TB] FAIL abort_grant: got %b want 00", grant); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL abort_tx_data: got %h want 00", tx_data); end
    ap0 = a_pops;
    settle(3);
    checks++; if (a_pops != ap0 || hs_data.size() != h0 + 30) begin errors++; $display("[TB] FAIL abort_quiet: got %0d pops %0d bytes want 0 pops 30 bytes", a_pops - ap0, hs_data.size() - h0); end
    rst = 1'b1;
    #1;
    g0 = gr_val.size(); h0 = hs_data.size();
    a_len = 16'd64; b_len = 16'd64;
    a_total++; b_total++;
    wait_hs(h0 + 128, 600, ok);
    checks++; if (gr_val.size() <= g0 || gr_val[g0] !== 2'b01) begin errors++; $display("[TB] FAIL abort_next_grant: got %0d grants want A first", gr_val.size() - g0); end
    checks++; if (!ok) begin errors++; $display("[TB] FAIL abort_resume: got %0d bytes want 128", hs_data.size() - h0); end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single_a();
    test_runt();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
